// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign fix-up at the end.
module mult_div_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d, step_acc;
    logic              is_div_q, is_div_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              dbz_q, dbz_d;
    logic              accept, op_signed;
    logic [XLEN:0]     rem_t, sum_t;
    logic [XLEN-1:0]   quo_t;
    logic [2*XLEN-1:0] work_t;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
        logic signed [XLEN-1:0] sv;
        sv = v;
        return (sgn && (sv < 0)) ? $unsigned(-sv) : v;
    endfunction

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? ((~v) + XLEN'(1)) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_if_wide(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? ((~v) + (2*XLEN)'(1)) : v;
    endfunction

    assign accept    = start && !flush && (op < 3'd6);
    assign op_signed = ~op[0];

    // Iteration datapath: BITS_PER_CYCLE unrolled single-bit steps per edge.
    // Multiply keeps {partial product, multiplier}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        work_t = acc_q;
        rem_t  = '0;
        sum_t  = '0;
        quo_t  = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (is_div_q) begin
                rem_t = {work_t[2*XLEN-1:XLEN], work_t[XLEN-1]};
                quo_t = {work_t[XLEN-2:0], 1'b0};
                if (rem_t >= {1'b0, opnd_q}) begin
                    rem_t    = rem_t - {1'b0, opnd_q};
                    quo_t[0] = 1'b1;
                end
                work_t = {rem_t[XLEN-1:0], quo_t};
            end else begin
                sum_t  = {1'b0, work_t[2*XLEN-1:XLEN]} + (work_t[0] ? {1'b0, opnd_q} : '0);
                work_t = {sum_t, work_t[XLEN-1:1]};
            end
        end
        step_acc = work_t;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dbz_d = 1'b0;
                    case (op)
                        OP_MTHI: hi_d = rs_data;
                        OP_MTLO: lo_d = rs_data;
                        OP_MULT, OP_MULTU: begin
                            opnd_d    = magnitude(rs_data, op_signed);
                            acc_d     = {{XLEN{1'b0}}, magnitude(rt_data, op_signed)};
                            neg_res_d = op_signed & (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
                            neg_rem_d = 1'b0;
                            is_div_d  = 1'b0;
                            cnt_d     = '0;
                            state_d   = S_CALC;
                        end
                        default: begin
                            if (rt_data == '0) begin
                                hi_d    = rs_data;
                                lo_d    = '1;
                                dbz_d   = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                opnd_d    = magnitude(rt_data, op_signed);
                                acc_d     = {{XLEN{1'b0}}, magnitude(rs_data, op_signed)};
                                neg_res_d = op_signed & (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
                                neg_rem_d = op_signed & rs_data[XLEN-1];
                                is_div_d  = 1'b1;
                                cnt_d     = '0;
                                state_d   = S_CALC;
                            end
                        end
                    endcase
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        lo_d = neg_if(acc_q[XLEN-1:0], neg_res_q);
                        hi_d = neg_if(acc_q[2*XLEN-1:XLEN], neg_rem_q);
                    end else begin
                        {hi_d, lo_d} = neg_if_wide(acc_q, neg_res_q);
                    end
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    always_ff @(posedge clk) begin
        opnd_q    <= opnd_d;
        acc_q     <= acc_d;
        is_div_q  <= is_div_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Serves the MIPS core's MULT, MULTU, DIV, DIVU, MTHI and MTLO instructions.
- Sits beside the ALU and takes the same rs/rt operands from the register file.
- Operates over several cycles behind a start/busy/done handshake; the core stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

## Interface
- XLEN, 32, operand and HI/LO width.
- BITS_PER_CYCLE, 1, quotient/multiplier bits retired per iteration; legal values 1, 2, 4; XLEN must be divisible by it.
- clk  input  1  sole clock; all state updates on rising edge.
- rst_b  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- start  input  1  request; sampled only when busy=0.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6,7 reserved (ignored).
- rs_data  input  XLEN  multiplicand / dividend / MTHI-MTLO source.
- rt_data  input  XLEN  multiplier / divisor.
- flush  input  1  abort an in-flight operation.
- busy  output  1  operation in progress; the core must not issue.
- done  output  1  one-cycle pulse when hi/lo have just been written by a mul/div.
- div_by_zero  output  1  sticky until next accepted start; set by DIV/DIVU with rt=0.
- hi  output  XLEN  HI register.
- lo  output  XLEN  LO register.

## Operation
- Reset: hi=0, lo=0, busy=0, done=0, div_by_zero=0, FSM=IDLE.
- FSM states and transitions:
  - IDLE: start accepted when busy=0 and op is legal.
    - MTHI/MTLO write rs_data to hi/lo at the same edge; stay IDLE; no busy, no done.
    - MULT/MULTU/DIV/DIVU latch operands and capture signs (signed ops only) → CALC. Accepting any op clears div_by_zero.
    - DIV/DIVU with rt_data=0 → DONE directly with lo={XLEN{1}}, hi=rs_data, div_by_zero=1.
  - CALC: works on operand magnitudes, N=XLEN/BITS_PER_CYCLE iterations.
    - Multiply: shift-add, 2·XLEN-bit product.
    - Divide: restoring, produces quotient and remainder.
    - After N iterations → FIXUP.
  - FIXUP: applies sign correction, then writes hi/lo → DONE.
    - Multiply: product negated if operand signs differ; hi=upper XLEN, lo=lower XLEN.
    - Divide: quotient negated if signs differ, truncating toward zero; remainder takes the dividend's sign; hi=remainder, lo=quotient.
  - DONE: done=1 for exactly this cycle → IDLE.
- Signed overflow: DIV of -2^(XLEN-1) by -1 gives lo=-2^(XLEN-1), hi=0, with no flag; this falls out of the magnitude datapath.
- flush: in CALC or FIXUP, return to IDLE next edge; hi/lo keep prior values; no done pulse. A flush in IDLE/DONE has no effect. If flush and start are both high in IDLE, flush wins and start is dropped.
- start while busy=1 is ignored; it is not queued.
- Reserved op: ignored, no state change.
- hi/lo are never partially updated: they change only at MTHI/MTLO accept, the FIXUP edge, or the div-by-zero accept.

## Timing
- busy is combinational from state: high in CALC, FIXUP and DONE; low in IDLE. It rises the cycle after the start edge.
- Mul/div latency: start sampled at edge 0 → done high in cycle N+2 (CALC edges 1..N, FIXUP edge N+1).
  - hi/lo are valid in the same cycle done is high, and remain so until the next write.
  - XLEN=32, BITS_PER_CYCLE=1: done at cycle 34. BITS_PER_CYCLE=4: done at cycle 10.
- Divide by zero: done in cycle 1; busy high only in cycle 1.
- MTHI/MTLO: hi/lo visible in the cycle after the start edge.
- Back-to-back: a new start is accepted at the first edge where busy=0, i.e. the edge ending the DONE cycle is not an accept edge; the earliest accept is the following edge.
- rst_b mid-operation: at the next edge all outputs return to their reset values and any partial result is discarded.

## Test plan
- MULT rs=-3 (0xFFFFFFFD), rt=7 → done at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU with the same operands → hi=0x00000006, lo=0xFFFFFFEB.
- DIV rs=-7, rt=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU rs=7, rt=2 → lo=3, hi=1.
- DIV rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0, div_by_zero=0. DIVU rs=5, rt=0 → done at cycle 1; lo=0xFFFFFFFF, hi=5, div_by_zero=1 until the next start.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles → hi/lo hold those values with no busy and no done. A later MULT with start asserted while busy → only the first operation completes, with exactly one done pulse.
- Start MULTU 0xFFFFFFFF×0xFFFFFFFF; assert flush at cycle 10 → busy=0 at cycle 11, no done, hi/lo unchanged. Repeat with rst_b at cycle 10 → hi=lo=0, all flags 0.
- Sweep BITS_PER_CYCLE ∈ {1,2,4} with XLEN ∈ {16,32} over 10k random signed and unsigned pairs against a reference model. Check result values, done cycle = XLEN/BITS_PER_CYCLE+2, and a single-cycle done pulse.
